serial_subtractor: RTL

Bit-serial two's-complement subtractor computing `d = a - b - bi` one bit per clock, LSB first, through a single full-subtractor cell. It trades the area of a parallel word-wide adder chain for `p_wordlength` cycles of latency. Valid/ready handshakes sit on both input and output, so it drops into streaming datapaths of the hierarchy examples.

---
 rtl/serial_subtractor_pkg.sv | 20 ++
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 93 +++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// FSM state encoding and counter width function.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < v) r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: x - y - bin.
// Purely combinational.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = x ^ y ^ bin;
   assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first,
// with valid/ready handshakes on both sides.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int p_wordlength = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [p_wordlength-1:0] a,
   input  logic [p_wordlength-1:0] b,
   input  logic                    bi,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [p_wordlength-1:0] d,
   output logic                    bo,
   output logic                    ov,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int W  = p_wordlength;
   localparam int CW = clog2(p_wordlength);

   if (p_wordlength < 2) begin : g_chk
      $error("serial_subtractor: p_wordlength must be >= 2");
   end

   state_t          state;
   logic [W-1:0]    a_sh;
   logic [W-1:0]    b_sh;
   logic [W-1:0]    d_sh;
   logic [CW-1:0]   cnt;
   logic            brw;
   logic            diff;
   logic            bout;

   full_subtractor u_fs (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .bin  (brw),
      .diff (diff),
      .bout (bout)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         d_sh  <= '0;
         cnt   <= '0;
         brw   <= 1'b0;
         d     <= '0;
         bo    <= 1'b0;
         ov    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  brw   <= bi;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               d_sh <= {diff, d_sh[W-1:1]};
               brw  <= bout;
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(W - 1)) begin
                  // brw is the borrow into the MSB here
                  d     <= {diff, d_sh[W-1:1]};
                  bo    <= bout;
                  ov    <= brw ^ bout;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
